// File: rtl/div.sv
// Multi-cycle integer divider: restoring shift-subtract, one quotient bit per cycle.
// Signed or unsigned per operation, with a fixed latency of Width+2 edges from acceptance to result.
module div #(
  parameter int Width = 32
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             start,
  input  logic [Width-1:0] dividend,
  input  logic [Width-1:0] divisor,
  input  logic             signed_op,
  output logic             ready,
  output logic [Width-1:0] quotient,
  output logic [Width-1:0] remainder
);

  localparam int CntW = $clog2(Width + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state, state_next;
  logic [CntW-1:0]   cnt;
  logic [Width-1:0]  rem_w, quo_w, div_w;
  logic              q_neg, r_neg;

  logic              a_neg, b_neg, take, calc_done;
  logic [Width-1:0]  a_mag, b_mag, diff;
  logic [Width:0]    shifted;

  // NOTE: combinational blocks assign every output first, so no latches are inferred.
  always_comb begin
    a_neg     = signed_op & dividend[Width-1];
    b_neg     = signed_op & divisor[Width-1];
    a_mag     = a_neg ? -dividend : dividend;
    b_mag     = b_neg ? -divisor : divisor;
    shifted   = {rem_w, quo_w[Width-1]};
    take      = (shifted >= {1'b0, div_w});
    diff      = shifted[Width-1:0] - div_w;
    calc_done = (cnt == CntW'(Width));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (calc_done) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      rem_w     <= '0;
      quo_w     <= '0;
      div_w     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt   <= '0;
          rem_w <= '0;
          quo_w <= a_mag;
          div_w <= b_mag;
          // A zero divisor keeps an all-ones quotient unnegated; the remainder sign still follows the dividend.
          q_neg <= (a_neg ^ b_neg) & (divisor != '0);
          r_neg <= a_neg;
        end
        CALC: if (!calc_done) begin
          cnt <= cnt + CntW'(1);
          if (take) begin
            rem_w <= diff;
            quo_w <= {quo_w[Width-2:0], 1'b1};
          end else begin
            rem_w <= shifted[Width-1:0];
            quo_w <= {quo_w[Width-2:0], 1'b0};
          end
        end
        FIX: begin
          quotient  <= q_neg ? -quo_w : quo_w;
          remainder <= r_neg ? -rem_w : rem_w;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed-vector bench for div (Width=32): results, fixed latency, output hold,
// ignored start during CALC, mid-operation reset and back-to-back operation.
module tb_div;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        signed_op;
  logic        ready;
  logic [31:0] quotient, remainder;

  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] last_q  = '0;
  logic [31:0] last_r  = '0;

  div #(.Width(32)) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .signed_op (signed_op),
    .ready     (ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts edges after the accepting edge until ready returns, bounded at 100.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk_sys); #1;
      n++;
    end while (!ready && n < 100);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er,
                        input bit disturb);
    int n;
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    check({tag, "_accept"}, {31'd0, ready}, 32'd0);
    n = 1;
    while (!ready && n < 100) begin
      if (disturb && n == 5) begin
        start = 1'b1; dividend = 32'd3; divisor = 32'd1; signed_op = 1'b1;
      end
      if (disturb && n == 6) start = 1'b0;
      if (n == 10) check({tag, "_hold_q"}, quotient, last_q);
      @(posedge clk_sys); #1;
      n++;
    end
    n--;
    check({tag, "_latency"}, n, 32'd34);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    last_q = eq; last_r = er;
  endtask

  logic [31:0] b2b_a [3] = '{32'd50, 32'hFFFF_FFCE, 32'h0000_FFFF};
  logic [31:0] b2b_b [3] = '{32'd7,  32'd7,         32'h0000_0100};
  logic        b2b_s [3] = '{1'b0,   1'b1,          1'b0};
  logic [31:0] b2b_q [3] = '{32'd7,  32'hFFFF_FFF9, 32'h0000_00FF};
  logic [31:0] b2b_r [3] = '{32'd1,  32'hFFFF_FFFF, 32'h0000_00FF};

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0; signed_op = 1'b0;
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    #11 rst_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1 check("release_idle", {31'd0, ready}, 32'd1);

    run_op("s_100_7",      32'd100,       32'd7,         1'b1, 32'd14,        32'd2,         1'b0);
    run_op("s_m100_7",     32'hFFFF_FF9C, 32'd7,         1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run_op("u_max_2",      32'hFFFF_FFFF, 32'd2,         1'b0, 32'h7FFF_FFFF, 32'd1,         1'b0);
    run_op("s_m1_2",       32'hFFFF_FFFF, 32'd2,         1'b1, 32'd0,         32'hFFFF_FFFF, 1'b0);
    run_op("u_div0",       32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5,         1'b0);
    run_op("s_div0",       32'd5,         32'd0,         1'b1, 32'hFFFF_FFFF, 32'd5,         1'b0);
    run_op("s_m5_div0",    32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);
    run_op("s_overflow",   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0);
    run_op("u_min_max",    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 1'b0);
    run_op("s_m7_m2",      32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3,         32'hFFFF_FFFF, 1'b0);
    run_op("s_7_m2",       32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0);
    run_op("u_disturb",    32'd1000,      32'd10,        1'b0, 32'd100,       32'd0,         1'b1);

    // Reset in the middle of CALC.
    dividend = 32'd1000; divisor = 32'd10; signed_op = 1'b0; start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    repeat (10) @(posedge clk_sys);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_q", quotient, 32'd0);
    check("midrst_r", remainder, 32'd0);
    #2 rst_n = 1'b1;
    last_q = '0; last_r = '0;
    repeat (3) @(posedge clk_sys);
    #1 check("midrst_no_start", {31'd0, ready}, 32'd1);
    run_op("after_rst_1_1", 32'd1, 32'd1, 1'b0, 32'd1, 32'd0, 1'b0);

    // Back-to-back with start held high.
    dividend = b2b_a[0]; divisor = b2b_b[0]; signed_op = b2b_s[0]; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_sys); #1;
      check($sformatf("b2b%0d_accept", i), {31'd0, ready}, 32'd0);
      if (i < 2) begin
        dividend = b2b_a[i+1]; divisor = b2b_b[i+1]; signed_op = b2b_s[i+1];
      end else begin
        start = 1'b0;
      end
      wait_done(n);
      check($sformatf("b2b%0d_latency", i), n, 32'd34);
      check($sformatf("b2b%0d_q", i), quotient, b2b_q[i]);
      check($sformatf("b2b%0d_r", i), remainder, b2b_r[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
